// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one combinational ALU
// between NUM_REQ requesters. One op in flight: IDLE (accept) -> EXEC (drive
// ALU) -> RESP (hold response until consumed).
// Optional feature: define ALU_ARB_LOCK_EN to let a requester keep the grant
// across several ops (req_lock), e.g. for atomic ADD-then-SAT sequences.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*5-1:0]  req_op,
  input  logic [NUM_REQ-1:0]    req_sat,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [4:0]            alu_op,
  output logic                  alu_saturate,
  input  logic [31:0]           alu_result,
  input  logic [3:0]            alu_flags,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic [3:0]            resp_flags,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] OP_LAST_LEGAL = 5'h17;

  state_t state, state_nxt;

  // per-requester views of the flattened operand buses
  logic [NUM_REQ-1:0][31:0] a_arr, b_arr;
  logic [NUM_REQ-1:0][4:0]  op_arr;
  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_op;

  logic [ID_W-1:0]    last_grant, pick;
  logic               pick_vld, accept;
  logic [NUM_REQ-1:0] elig;

  // issue register: the op currently owned by the ALU
  logic [31:0]     iss_a, iss_b;
  logic [4:0]      iss_op;
  logic            iss_sat;
  logic [ID_W-1:0] iss_id;

`ifdef ALU_ARB_LOCK_EN
  logic            locked;
  logic [ID_W-1:0] lock_owner;

  // while locked, only the owner may be granted
  always_comb begin
    elig = req_valid;
    if (locked) elig = req_valid & (NUM_REQ'(1) << lock_owner);
  end

  // lock set by an accepted op with req_lock, cleared by owner's unlocked op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (accept) begin
      if (req_lock[pick]) begin
        locked     <= 1'b1;
        lock_owner <= pick;
      end else begin
        locked     <= 1'b0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign elig        = req_valid;
`endif

  // round-robin search from last_grant+1; smallest distance wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (elig[c] && ((int'(last_grant) + k) % NUM_REQ) == c) begin
          pick     = ID_W'(c);
          pick_vld = 1'b1;
        end
      end
    end
  end

  // ready is gated by reset so it reads zero while rst_n is held low
  assign accept    = rst_n && (state == IDLE) && pick_vld;
  assign req_ready = accept ? (NUM_REQ'(1) << pick) : '0;

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // arbitration pointer; frozen while a lock is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
`ifdef ALU_ARB_LOCK_EN
      if (!locked) last_grant <= pick;
`else
      last_grant <= pick;
`endif
    end
  end

  // latch the winner's op; these also hold the ALU inputs between ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_a   <= '0;
      iss_b   <= '0;
      iss_op  <= '0;
      iss_sat <= 1'b0;
      iss_id  <= '0;
    end else if (accept) begin
      iss_a   <= a_arr[pick];
      iss_b   <= b_arr[pick];
      iss_op  <= op_arr[pick];
      iss_sat <= req_sat[pick];
      iss_id  <= pick;
    end
  end

  assign alu_a        = iss_a;
  assign alu_b        = iss_b;
  assign alu_op       = iss_op;
  assign alu_saturate = (state == EXEC) && iss_sat;

  // capture ALU output at the end of EXEC; illegal opcodes return a clean error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id    <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      resp_err   <= 1'b0;
    end else if (state == EXEC) begin
      resp_id <= iss_id;
      if (iss_op > OP_LAST_LEGAL) begin
        resp_data  <= '0;
        resp_flags <= '0;
        resp_err   <= 1'b1;
      end else begin
        resp_data  <= alu_result;
        resp_flags <= alu_flags;
        resp_err   <= 1'b0;
      end
    end
  end

  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized checks of alu_arbiter against a
// transaction-level model (round-robin pick, optional lock, ALU function).
module tb_alu_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_ready, req_sat, req_lock;
  logic [NUM_REQ*32-1:0] req_a, req_b;
  logic [NUM_REQ*5-1:0]  req_op;
  logic [31:0]           alu_a, alu_b, alu_result;
  logic [4:0]            alu_op;
  logic                  alu_saturate;
  logic [3:0]            alu_flags;
  logic                  resp_valid, resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic [3:0]            resp_flags;
  logic                  resp_err;

  int checks = 0;
  int errors = 0;

  // model state
  int m_last;
  bit m_locked;
  int m_owner;
  // last transaction as seen by the bench
  int          last_g;
  logic [31:0] last_data;
  logic [3:0]  last_flags;

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_sat(req_sat), .req_lock(req_lock),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_saturate(alu_saturate),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // stand-in ALU: returns {flags, result}, flags = {zero, overflow, carry, negative}
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] op, input logic sat);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov, cy;
    s = 33'd0; ov = 1'b0; cy = 1'b0;
    case (op)
      5'h00: begin
        s  = {1'b0, a} + {1'b0, b};
        cy = s[32];
        ov = (a[31] == b[31]) && (s[31] != a[31]);
        r  = s[31:0];
      end
      5'h01: begin
        s  = {1'b0, a} - {1'b0, b};
        cy = s[32];
        ov = (a[31] != b[31]) && (s[31] != a[31]);
        r  = s[31:0];
      end
      5'h02:   r = a & b;
      5'h03:   r = a | b;
      5'h04:   r = a ^ b;
      default: r = a ^ (b << op[2:0]);
    endcase
    if (sat && ov) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {(r == 32'd0), ov, cy, r[31], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_op, alu_saturate);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic sat, input logic lk, input logic v);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*5 +: 5]  = op;
    req_sat[r]        = sat;
    req_lock[r]       = lk;
    req_valid[r]      = v;
  endtask

  // next winner from the arbitration rules
  function automatic int model_pick(input logic [NUM_REQ-1:0] v);
`ifdef ALU_ARB_LOCK_EN
    if (m_locked) return v[m_owner] ? m_owner : -1;
`endif
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_last   = NUM_REQ - 1;
    m_locked = 1'b0;
    m_owner  = 0;
  endtask

  // one full operation: accept, EXEC, RESP (hold cycles with resp_ready low)
  task automatic txn(input int hold, input bit drop, input int exp_wait);
    int          w, g;
    logic [31:0] ea, eb, ed;
    logic [4:0]  eo;
    logic        es, ee;
    logic [3:0]  ef;
    logic [35:0] rf;
    w = 0;
    #1;
    while (req_ready == '0 && w < 30) begin
      @(posedge clk);
      #2;
      w++;
    end
    g = model_pick(req_valid);
    last_g = g;
    chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    if (exp_wait >= 0) chk("accept_wait", 32'(w), 32'(exp_wait));
    if (g < 0 || req_ready == '0) return;
    ea = req_a[g*32 +: 32];
    eb = req_b[g*32 +: 32];
    eo = req_op[g*5 +: 5];
    es = req_sat[g];
    rf = alu_fn(ea, eb, eo, es);
    ee = (eo >= 5'h18);
    ed = ee ? 32'd0 : rf[31:0];
    ef = ee ? 4'd0 : rf[35:32];
`ifdef ALU_ARB_LOCK_EN
    if (!m_locked) m_last = g;
    if (req_lock[g]) begin m_locked = 1'b1; m_owner = g; end
    else m_locked = 1'b0;
`else
    m_last = g;
`endif
    // EXEC
    tick();
    if (drop) req_valid[g] = 1'b0;
    resp_ready = (hold == 0);
    #1;
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_resp_valid", 32'(resp_valid), 32'd0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", 32'(alu_op), 32'(eo));
    chk("exec_alu_sat", 32'(alu_saturate), 32'(es));
    // RESP
    @(posedge clk);
    #2;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_id", 32'(resp_id), 32'(g));
    chk("resp_data", resp_data, ed);
    chk("resp_flags", 32'(resp_flags), 32'(ef));
    chk("resp_err", 32'(resp_err), 32'(ee));
    chk("resp_ready_zero", 32'(req_ready), 32'd0);
    chk("resp_alu_sat", 32'(alu_saturate), 32'd0);
    chk("resp_alu_a_hold", alu_a, ea);
    last_data  = resp_data;
    last_flags = resp_flags;
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk);
        #2;
        chk("bp_valid", 32'(resp_valid), 32'd1);
        chk("bp_data", resp_data, ed);
        chk("bp_id", 32'(resp_id), 32'(g));
        chk("bp_flags", 32'(resp_flags), 32'(ef));
        chk("bp_ready_zero", 32'(req_ready), 32'd0);
      end
      tick();
      resp_ready = 1'b1;
      #1;
      chk("bp_last_valid", 32'(resp_valid), 32'd1);
      chk("bp_last_data", resp_data, ed);
    end
    tick();
  endtask

  int grants[$];
  int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
  int exp_lock[4] = '{1, 1, 3, 0};

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    req_sat    = '0;
    req_lock   = '0;
    resp_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_flags", 32'(resp_flags), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_sat", 32'(alu_saturate), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // fairness: everyone requesting continuously
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 32'(r + 1), 32'(r * 3), 5'h00, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++) begin
      txn(0, 1'b0, 0);
      grants.push_back(last_g);
    end
    for (int t = 0; t < 6; t++) chk("fair_order", 32'(grants[t]), 32'(exp_fair[t]));
    req_valid = '0;

    // single op from req0
    set_req(0, 32'h10, 32'h20, 5'h00, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b1, 0);
    chk("single_data", last_data, 32'h30);
    chk("single_flags", 32'(last_flags), 32'd0);

    // backpressure, then immediate next accept
    set_req(0, 32'h1234, 32'h0F0F, 5'h04, 1'b0, 1'b0, 1'b1);
    txn(5, 1'b1, 0);
    set_req(3, 32'h5, 32'h7, 5'h01, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b1, 0);

    // saturating add
    set_req(2, 32'h7FFF_FFFF, 32'h1, 5'h00, 1'b1, 1'b0, 1'b1);
    txn(0, 1'b1, 0);
    chk("sat_data", last_data, 32'h7FFF_FFFF);
    chk("sat_ovf", 32'(last_flags[2]), 32'd1);
    chk("sat_id", 32'(last_g), 32'd2);

    // illegal opcode
    set_req(1, 32'hDEAD, 32'hBEEF, 5'h18, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b1, 0);
    chk("illegal_data", last_data, 32'd0);

    // reset during EXEC
    set_req(3, 32'h55, 32'h66, 5'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_resp_data", resp_data, 32'd0);
    chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
    req_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    set_req(0, 32'h3, 32'h4, 5'h02, 1'b0, 1'b0, 1'b1);
    set_req(3, 32'h8, 32'h9, 5'h03, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b1, 0);
    chk("post_rst_grant", 32'(last_g), 32'd0);
    req_valid = '0;

    // lock sequence: req1 ADD(lock) then SAT(unlock), req0/req3 waiting
    grants.delete();
    set_req(0, 32'h1, 32'h1, 5'h03, 1'b0, 1'b0, 1'b1);
    set_req(1, 32'h7FFF_FFF0, 32'h20, 5'h00, 1'b0, 1'b1, 1'b1);
    set_req(3, 32'h2, 32'h2, 5'h04, 1'b0, 1'b0, 1'b1);
    txn(0, 1'b0, 0);
    grants.push_back(last_g);
    set_req(1, 32'h7FFF_FFF0, 32'h20, 5'h00, 1'b1, 1'b0, 1'b1);
    for (int t = 0; t < 3; t++) begin
      txn(0, 1'b1, 0);
      grants.push_back(last_g);
    end
`ifdef ALU_ARB_LOCK_EN
    for (int t = 0; t < 4; t++) chk("lock_order", 32'(grants[t]), 32'(exp_lock[t]));
`endif
    req_valid = '0;
    req_lock  = '0;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < NUM_REQ; r++)
        set_req(r, $urandom, ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      txn($urandom_range(0, 2), 1'b1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational DSP ALU between up to NUM_REQ requesters, such as the integer pipe, the DSP loop unit and the debug port. It accepts one operation at a time over a valid/ready handshake, registers operands and drives the ALU's a/b/alu_op/saturate inputs. It captures result and flags into a response register and returns them, tagged with the requester ID, over a second valid/ready handshake.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, $clog2(NUM_REQ): width of requester ID.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a, req_b  in  NUM_REQ*32  flattened operands; requester i occupies bits [32i+31:32i].
- req_op  in  NUM_REQ*5  flattened ALU opcodes.
- req_sat  in  NUM_REQ  saturate-mode bits.
- req_lock  in  NUM_REQ  hold grant after this op; used only with ALU_ARB_LOCK_EN.
- alu_a, alu_b  out  32  ALU operands.
- alu_op  out  5  ALU opcode.
- alu_saturate  out  1  ALU saturate input.
- alu_result  in  32  ALU result.
- alu_flags  in  4  {zero, overflow, carry, negative} from the ALU.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester that issued the op.
- resp_data  out  32  captured result.
- resp_flags  out  4  captured flags.
- resp_err  out  1  illegal opcode.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE → EXEC: when any eligible req_valid is high.
  - The arbiter picks winner g and asserts req_ready[g] combinationally in that cycle.
  - Operands, op, sat, ID and lock are latched into the issue register.
- Round-robin rule: the search starts at last_grant+1 mod NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- last_grant updates to g on every accept.
- EXEC → RESP, unconditional after one cycle:
  - alu_a, alu_b, alu_op and alu_saturate are driven from the issue register.
  - alu_result and alu_flags are captured into the response register at the end of EXEC.
- Legal opcodes: 5'h00–5'h17.
- Illegal opcode (5'h18–5'h1F): still passes through EXEC. The response is forced to resp_data=0, resp_flags=0, resp_err=1.
- RESP → IDLE: on resp_valid && resp_ready.
  - No request is accepted in the same cycle.
  - resp_* stay stable while resp_ready is low.
- Outside EXEC, alu_a, alu_b and alu_op hold their last issued values. alu_saturate=0.
- req_ready is all-zero in EXEC and RESP.
- Only one operation is outstanding at any time.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_flags=0, resp_err=0.
  - alu_a=0, alu_b=0, alu_op=0, alu_saturate=0.
  - last_grant=NUM_REQ-1, lock cleared.
- Accept in cycle N; EXEC in cycle N+1; resp_valid=1 from cycle N+2.
- Minimum issue interval is 3 cycles, with resp_ready held high.
- A requester may drop req_valid before it is granted; no state is retained for it.
- Reset asserted mid-operation: asynchronous return to IDLE. The pending op and response are discarded and all outputs go to their reset values.
- A req_valid arriving in the same cycle as a RESP handshake is considered in the next cycle.

## Configuration
- ALU_ARB_LOCK_EN defined:
  - An accepted op with req_lock=1 sets lock_owner=g.
  - While the lock is set, only lock_owner is eligible in IDLE, and last_grant is not advanced.
  - The lock is cleared when lock_owner's next op is accepted with req_lock=0.
  - Used for atomic sequences such as ADD then SAT.
- ALU_ARB_LOCK_EN undefined: req_lock is ignored, no lock register exists, and arbitration is pure round-robin.

## Test plan
- Single op: req0 ADD, a=0x10, b=0x20, resp_ready=1.
  - Required: req_ready[0] high in accept cycle N; resp_valid at N+2.
  - Required: resp_data=0x30, resp_id=0, resp_flags=4'b0000, resp_err=0.
- Fairness: all four req_valid held high continuously.
  - Required: grant order 0,1,2,3,0,1; one accept every 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_* stable, req_ready all-zero.
  - Required: the next accept occurs in the cycle after resp_ready goes high.
- Saturation: req2 ADD, a=0x7FFFFFFF, b=1, sat=1.
  - Required: resp_data=0x7FFFFFFF, resp_flags overflow bit=1, resp_id=2.
- Illegal opcode and reset:
  - req1 op=5'h18 → resp_err=1, resp_data=0, resp_flags=0.
  - rst_n pulsed low during EXEC → resp_valid never asserts; next grant goes to req0.
- Lock (ALU_ARB_LOCK_EN): req1 issues ADD lock=1, then SAT lock=0, with req0 and req3 valid throughout.
  - Required: grants are 1,1, then 3,0.
